// File: rtl/cache_port_arbiter_if.sv
// rtl/cache_port_arbiter_if.sv - client and RAM-port bundle for cache_port_arbiter
// slave is the arbiter side; master is the client/RAM side.
interface cache_port_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 19,
  parameter int NUM_RD     = 4
);
  logic [NUM_RD-1:0]            rd_req;
  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr;
  logic [NUM_RD-1:0]            rd_gnt;
  logic [NUM_RD-1:0]            rd_rvalid;
  logic [DATA_WIDTH-1:0]        rd_rdata;
  logic                         wr_req;
  logic [ADDR_WIDTH-1:0]        wr_addr;
  logic [DATA_WIDTH-1:0]        wr_data;
  logic                         wr_gnt;
  logic                         init_done;
  logic [ADDR_WIDTH-1:0]        ram_addra;
  logic [DATA_WIDTH-1:0]        ram_dina;
  logic                         ram_wea;
  logic [ADDR_WIDTH-1:0]        ram_addrb;
  logic [DATA_WIDTH-1:0]        ram_doutb;

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data, ram_doutb,
    output rd_gnt, rd_rvalid, rd_rdata, wr_gnt, init_done,
           ram_addra, ram_dina, ram_wea, ram_addrb
  );

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data, ram_doutb,
    input  rd_gnt, rd_rvalid, rd_rdata, wr_gnt, init_done,
           ram_addra, ram_dina, ram_wea, ram_addrb
  );
endinterface

// File: rtl/cache_port_arbiter.sv
// rtl/cache_port_arbiter.sv - zero-sweep init, write port A, round-robin read port B
// CACHE_ARB_WR_BYPASS_EN: forward same-cycle write data to a colliding read return.
module cache_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 19,
  parameter int NUM_RD     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cache_port_arbiter_if.slave  bus
);
  localparam int PTR_W = $clog2(NUM_RD);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]  addrb_q, addrb_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic                   init_done_q, init_done_d;
  logic [NUM_RD-1:0]      rvalid_q;

  logic [NUM_RD-1:0]      gnt;
  logic                   gnt_any;
  logic [PTR_W-1:0]       win;
  logic [PTR_W-1:0]       idx;
  logic                   running;

  assign running = (state_q == ST_RUN);

  // Rotating priority: first requester at or above the pointer, wrapping.
  always_comb begin
    gnt     = '0;
    gnt_any = 1'b0;
    win     = '0;
    idx     = '0;
    if (running) begin
      for (int k = 0; k < NUM_RD; k++) begin
        idx = PTR_W'((int'(ptr_q) + k) % NUM_RD);
        if (!gnt_any && bus.rd_req[idx]) begin
          gnt_any = 1'b1;
          win     = idx;
        end
      end
    end
    if (gnt_any) gnt[win] = 1'b1;
  end

  assign bus.rd_gnt    = gnt;
  assign bus.ram_addrb = gnt_any ? bus.rd_addr[int'(win)*ADDR_WIDTH +: ADDR_WIDTH] : addrb_q;

  assign bus.ram_wea   = running ? bus.wr_req  : 1'b1;
  assign bus.ram_addra = running ? bus.wr_addr : cnt_q;
  assign bus.ram_dina  = running ? bus.wr_data : '0;
  assign bus.wr_gnt    = running & bus.wr_req;
  assign bus.init_done = init_done_q;

  // A reset landing on the return cycle still kills that return.
  assign bus.rd_rvalid = rvalid_q & {NUM_RD{rst_n}};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    ptr_d       = ptr_q;
    addrb_d     = bus.ram_addrb;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (&cnt_q) begin
        state_d     = ST_RUN;
        init_done_d = 1'b1;
      end
    end
    if (gnt_any) ptr_d = (int'(win) == NUM_RD - 1) ? '0 : win + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      ptr_q       <= '0;
      init_done_q <= 1'b0;
      rvalid_q    <= '0;
      addrb_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      init_done_q <= init_done_d;
      rvalid_q    <= gnt;
      addrb_q     <= addrb_d;
    end
  end

`ifdef CACHE_ARB_WR_BYPASS_EN
  logic                  byp_q;
  logic [DATA_WIDTH-1:0] byp_data_q;
  logic                  collision;

  assign collision = gnt_any & bus.wr_req & (bus.wr_addr == bus.ram_addrb);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byp_q <= 1'b0;
    end else begin
      byp_q <= collision;
    end
  end

  always_ff @(posedge clk) begin
    if (collision) byp_data_q <= bus.wr_data;
  end

  assign bus.rd_rdata = byp_q ? byp_data_q : bus.ram_doutb;
`else
  assign bus.rd_rdata = bus.ram_doutb;
`endif
endmodule

// File: tb/tb_cache_port_arbiter.sv
// tb/tb_cache_port_arbiter.sv - directed bench with cycle model for cache_port_arbiter
module tb_cache_port_arbiter;
  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int NR    = 4;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  cache_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR)) bus ();

  cache_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Read-first RAM: old word on port B when A writes the same address.
  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (bus.ram_wea) ram[bus.ram_addra] <= bus.ram_dina;
    bus.ram_doutb <= ram[bus.ram_addrb];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_addr(input int c, input logic [AW-1:0] a);
    bus.rd_addr[c*AW +: AW] = a;
  endtask

  function automatic int winner(input int p, input logic [NR-1:0] req);
    for (int k = 0; k < NR; k++)
      if (req[(p + k) % NR]) return (p + k) % NR;
    return -1;
  endfunction

  // Model state: sweep progress, rotating pointer, last grant and its data.
  logic [DW-1:0] mmem [DEPTH];
  bit            started = 1'b0;
  int            init_cnt = 0;
  int            ptr = 0;
  int            prev_gnt = -1;
  logic [DW-1:0] prev_data = '0;

  always @(negedge clk) begin
    bit            run;
    int            w;
    logic [AW-1:0] a;
    logic [NR-1:0] exp_gnt;
    if (started) begin
      run     = (init_cnt >= DEPTH);
      w       = run ? winner(ptr, bus.rd_req) : -1;
      exp_gnt = (w >= 0) ? NR'(1 << w) : '0;
      chk("m_init_done", 32'(bus.init_done), 32'(run));
      chk("m_rd_gnt", 32'(bus.rd_gnt), 32'(exp_gnt));
      chk("m_wr_gnt", 32'(bus.wr_gnt), 32'(run && bus.wr_req));
      chk("m_ram_wea", 32'(bus.ram_wea), 32'(run ? bus.wr_req : 1'b1));
      if (!run) begin
        chk("m_ram_addra", 32'(bus.ram_addra), 32'(init_cnt));
        chk("m_ram_dina", bus.ram_dina, 32'h0);
      end else if (bus.wr_req) begin
        chk("m_ram_addra", 32'(bus.ram_addra), 32'(bus.wr_addr));
        chk("m_ram_dina", bus.ram_dina, bus.wr_data);
      end
      if (w >= 0) chk("m_ram_addrb", 32'(bus.ram_addrb), 32'(bus.rd_addr[w*AW +: AW]));
      chk("m_rd_rvalid", 32'(bus.rd_rvalid),
          (rst_n && prev_gnt >= 0) ? 32'(1 << prev_gnt) : 32'h0);
      if (rst_n && prev_gnt >= 0) chk("m_rd_rdata", bus.rd_rdata, prev_data);
    end
    // Advance to the state after the coming rising edge; inputs are stable until then.
    if (!rst_n) begin
      started  = 1'b1;
      init_cnt = 0;
      ptr      = 0;
      prev_gnt = -1;
    end else if (started) begin
      if (init_cnt < DEPTH) begin
        mmem[init_cnt] = '0;
        init_cnt++;
        prev_gnt = -1;
      end else begin
        w = winner(ptr, bus.rd_req);
        prev_gnt = w;
        if (w >= 0) begin
          a = bus.rd_addr[w*AW +: AW];
          prev_data = mmem[a];
`ifdef CACHE_ARB_WR_BYPASS_EN
          if (bus.wr_req && bus.wr_addr == a) prev_data = bus.wr_data;
`endif
          ptr = (w + 1) % NR;
        end
        if (bus.wr_req) mmem[bus.wr_addr] = bus.wr_data;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [3:0]  t4_exp [3];
  logic [31:0] t5_exp;

  initial begin
    rst_n       = 1'b0;
    bus.rd_req  = '0;
    bus.rd_addr = '0;
    bus.wr_req  = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    for (int i = 0; i < NR; i++) set_addr(i, AW'(i + 8));
    repeat (2) @(posedge clk);
    #1;
    rst_n      = 1'b1;
    bus.rd_req = 4'hF;

    // Sweep: 16 cycles of zero writes, no grants.
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      chk("t1_init_done_low", 32'(bus.init_done), 32'h0);
      chk("t1_gnt_zero", 32'(bus.rd_gnt), 32'h0);
      chk("t1_addra", 32'(bus.ram_addra), 32'(i));
      chk("t1_dina", bus.ram_dina, 32'h0);
      step();
    end

    // Cycle 17 onwards: all four requesting, full rotation twice.
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) chk("t1_init_done_high", 32'(bus.init_done), 32'h1);
      chk("t3_gnt", 32'(bus.rd_gnt), 32'(1 << (k % 4)));
      chk("t3_rvalid", 32'(bus.rd_rvalid), (k == 0) ? 32'h0 : 32'(1 << ((k - 1) % 4)));
      step();
      if (k == 7) bus.rd_req = 4'h0;
    end

    // Write then read back through client 2.
    bus.wr_req  = 1'b1;
    bus.wr_addr = 4'd5;
    bus.wr_data = 32'hA5A5_0001;
    step();
    bus.wr_req = 1'b0;
    bus.rd_req = 4'b0100;
    set_addr(2, 4'd5);
    @(negedge clk);
    chk("t2_gnt", 32'(bus.rd_gnt), 32'h4);
    step();
    bus.rd_req = 4'h0;
    @(negedge clk);
    chk("t2_rvalid", 32'(bus.rd_rvalid), 32'h4);
    chk("t2_rdata", bus.rd_rdata, 32'hA5A5_0001);

    // Pointer to 2 via a client-1 grant, then clients 0/1 only.
    step();
    bus.rd_req = 4'b0010;
    @(negedge clk);
    chk("t4_setup_gnt", 32'(bus.rd_gnt), 32'h2);
    step();
    bus.rd_req = 4'b0011;
    t4_exp[0] = 4'b0001;
    t4_exp[1] = 4'b0010;
    t4_exp[2] = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t4_gnt", 32'(bus.rd_gnt), 32'(t4_exp[k]));
      step();
    end
    bus.rd_req = 4'h0;

    // Read and write of address 7 in the same cycle.
`ifdef CACHE_ARB_WR_BYPASS_EN
    t5_exp = 32'h0000_1234;
`else
    t5_exp = 32'h0000_0000;
`endif
    set_addr(0, 4'd7);
    bus.rd_req  = 4'b0001;
    bus.wr_req  = 1'b1;
    bus.wr_addr = 4'd7;
    bus.wr_data = 32'h0000_1234;
    @(negedge clk);
    chk("t5_gnt", 32'(bus.rd_gnt), 32'h1);
    step();
    bus.rd_req = 4'h0;
    bus.wr_req = 1'b0;
    @(negedge clk);
    chk("t5_rvalid", 32'(bus.rd_rvalid), 32'h1);
    chk("t5_rdata", bus.rd_rdata, t5_exp);

    // Grant, then reset for one cycle in the return cycle.
    step();
    bus.rd_req = 4'b0010;
    @(negedge clk);
    chk("t6_gnt", 32'(bus.rd_gnt), 32'h2);
    step();
    bus.rd_req = 4'h0;
    rst_n      = 1'b0;
    @(negedge clk);
    chk("t6_rvalid_killed", 32'(bus.rd_rvalid), 32'h0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_rvalid_after", 32'(bus.rd_rvalid), 32'h0);
    chk("t6_addra_restart", 32'(bus.ram_addra), 32'h0);
    chk("t6_wea", 32'(bus.ram_wea), 32'h1);
    chk("t6_init_done_low", 32'(bus.init_done), 32'h0);
    repeat (16) @(posedge clk);
    @(negedge clk);
    chk("t6_init_done_high", 32'(bus.init_done), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
